// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: registered N-channel mux with manual select and round-robin scan; define MUX_SCAN_BLANK_EN for one-cycle blanking after each channel change
module mux_nx1_scan #(
   parameter int WIDTH    = 7,
   parameter int CHANNELS = 4,
   parameter int PERIOD   = 4,
   localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] D,
   input  logic [SELW-1:0]           SEL,
   input  logic                      MODE,
   input  logic                      HOLD,
   output logic [WIDTH-1:0]          OUT,
   output logic [SELW-1:0]           CUR_SEL,
   output logic                      WRAP
);
   localparam int TW = $clog2(PERIOD + 1);
   localparam logic [SELW:0]   CH_N  = (SELW + 1)'(CHANNELS);
   localparam logic [SELW-1:0] LAST  = SELW'(CHANNELS - 1);
   localparam logic [TW-1:0]   TLAST = TW'(PERIOD - 1);
   logic [WIDTH-1:0] ch [CHANNELS];
   logic [WIDTH-1:0] out_q, out_d;
   logic [SELW-1:0]  sel_q, sel_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic             wrap_q, wrap_d, adv;
`ifdef MUX_SCAN_BLANK_EN
   logic             chg_q, chg_d;
`endif
   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      assign ch[k] = D[k*WIDTH +: WIDTH];
   end
   always_comb begin
      adv    = MODE && !HOLD && tmr_q == TLAST;
      tmr_d  = (!MODE || adv) ? '0 : HOLD ? tmr_q : tmr_q + 1'b1;
      sel_d  = !MODE ? (({1'b0, SEL} < CH_N) ? SEL : sel_q)
             : !adv ? sel_q : (sel_q == LAST) ? '0 : sel_q + 1'b1;
      wrap_d = adv && sel_q == LAST;
`ifdef MUX_SCAN_BLANK_EN
      chg_d  = sel_d != sel_q;
      out_d  = chg_q ? '0 : ch[sel_q];
`else
      out_d  = ch[sel_q];
`endif
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         out_q  <= '0;
         sel_q  <= '0;
         tmr_q  <= '0;
         wrap_q <= 1'b0;
`ifdef MUX_SCAN_BLANK_EN
         chg_q  <= 1'b0;
`endif
      end else begin
         out_q  <= out_d;
         sel_q  <= sel_d;
         tmr_q  <= tmr_d;
         wrap_q <= wrap_d;
`ifdef MUX_SCAN_BLANK_EN
         chg_q  <= chg_d;
`endif
      end
   end
   assign OUT     = out_q;
   assign CUR_SEL = sel_q;
   assign WRAP    = wrap_q;
endmodule

// File: tb/tb_mux_nx1_scan.sv
// tb_mux_nx1_scan: three DUT configurations (4ch/P4, 3ch/P4, 4ch/P1) checked against a dwell-countdown model
module tb_mux_nx1_scan;
`ifdef MUX_SCAN_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif
   logic        clock = 1'b0, reset, mode, hold;
   logic [1:0]  sel;
   logic [27:0] d;
   logic [6:0]  out_a, out_b, out_c;
   logic [1:0]  cs_a, cs_b, cs_c;
   logic        wr_a, wr_b, wr_c;
   int checks = 0, errors = 0;
   int nc[3] = '{4, 3, 4};
   int np[3] = '{4, 4, 1};
   int m_sel[3], m_left[3], m_out[3], m_wrap[3];
   bit m_chg[3];
   typedef struct {bit rst; bit md; bit hd; logic [1:0] s; int ea; int eb;} vec_t;
   vec_t tbl[13];
   always #5 clock = ~clock;
   mux_nx1_scan #(.WIDTH(7), .CHANNELS(4), .PERIOD(4)) dut_a (.clock(clock), .reset(reset), .D(d),
      .SEL(sel), .MODE(mode), .HOLD(hold), .OUT(out_a), .CUR_SEL(cs_a), .WRAP(wr_a));
   mux_nx1_scan #(.WIDTH(7), .CHANNELS(3), .PERIOD(4)) dut_b (.clock(clock), .reset(reset), .D(d[20:0]),
      .SEL(sel), .MODE(mode), .HOLD(hold), .OUT(out_b), .CUR_SEL(cs_b), .WRAP(wr_b));
   mux_nx1_scan #(.WIDTH(7), .CHANNELS(4), .PERIOD(1)) dut_c (.clock(clock), .reset(reset), .D(d),
      .SEL(sel), .MODE(mode), .HOLD(hold), .OUT(out_c), .CUR_SEL(cs_c), .WRAP(wr_c));
   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      checks++;
      if (act !== 32'(exp)) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   // m_left counts cycles still owed to the current channel, a dwell rather than a timer
   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         int ns, nl, data;
         if (reset) begin
            m_sel[i] = 0; m_left[i] = np[i]; m_out[i] = 0; m_wrap[i] = 0; m_chg[i] = 0;
         end else begin
            data = int'((d >> (m_sel[i] * 7)) & 28'h7F);
            ns = m_sel[i]; nl = m_left[i]; m_wrap[i] = 0;
            if (!mode) begin
               if (int'(sel) < nc[i]) ns = int'(sel);
               nl = np[i];
            end else if (!hold) begin
               if (m_left[i] == 1) begin
                  ns = (m_sel[i] + 1) % nc[i]; nl = np[i]; m_wrap[i] = int'(ns == 0);
               end else nl = m_left[i] - 1;
            end
            m_out[i] = (BLANK && m_chg[i]) ? 0 : data;
            m_chg[i] = ns != m_sel[i];
            m_sel[i] = ns; m_left[i] = nl;
         end
      end
   endtask
   task automatic compare();
      chk("model_sel_a", cs_a, m_sel[0]); chk("model_out_a", out_a, m_out[0]); chk("model_wrap_a", wr_a, m_wrap[0]);
      chk("model_sel_b", cs_b, m_sel[1]); chk("model_out_b", out_b, m_out[1]); chk("model_wrap_b", wr_b, m_wrap[1]);
      chk("model_sel_c", cs_c, m_sel[2]); chk("model_out_c", out_c, m_out[2]); chk("model_wrap_c", wr_c, m_wrap[2]);
   endtask
   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      compare();
   endtask
   initial begin
      int wraps;
      tbl = '{
         '{1'b1, 1'b0, 1'b0, 2'd0, 0, 0},
         '{1'b1, 1'b0, 1'b0, 2'd0, 0, 0},
         '{1'b0, 1'b0, 1'b0, 2'd2, 2, 2},
         '{1'b0, 1'b0, 1'b0, 2'd1, 1, 1},
         '{1'b0, 1'b0, 1'b0, 2'd3, 3, 1},
         '{1'b0, 1'b0, 1'b0, 2'd3, 3, 1},
         '{1'b0, 1'b0, 1'b0, 2'd0, 0, 0},
         '{1'b0, 1'b1, 1'b0, 2'd3, 0, 0},
         '{1'b0, 1'b1, 1'b0, 2'd3, 0, 0},
         '{1'b0, 1'b1, 1'b0, 2'd3, 0, 0},
         '{1'b0, 1'b1, 1'b0, 2'd3, 1, 1},
         '{1'b0, 1'b1, 1'b1, 2'd3, 1, 1},
         '{1'b0, 1'b1, 1'b0, 2'd3, 1, 1}};
      d = {7'h11, 7'h5A, 7'h33, 7'h22};
      reset = 1'b1; mode = 1'b0; hold = 1'b0; sel = 2'd0;
      tick(); tick();
      chk("reset_out", out_a, 0); chk("reset_sel", cs_a, 0); chk("reset_wrap", wr_a, 0);
      reset = 1'b0; sel = 2'd2;
      tick(); chk("manual_sel_lat1", cs_a, 2);
      tick(); chk("manual_out_lat2", out_a, BLANK ? 0 : 'h5A);
      tick(); chk("manual_out_steady", out_a, 'h5A);
      for (int i = 0; i < 13; i++) begin
         reset = tbl[i].rst; mode = tbl[i].md; hold = tbl[i].hd; sel = tbl[i].s;
         tick();
         chk($sformatf("tbl%0d_sel_a", i), cs_a, tbl[i].ea);
         chk($sformatf("tbl%0d_sel_b", i), cs_b, tbl[i].eb);
         chk($sformatf("tbl%0d_wrap_a", i), wr_a, 0);
      end
      reset = 1'b1; mode = 1'b1; hold = 1'b0; wraps = 0;
      tick();
      reset = 1'b0;
      for (int n = 1; n <= 48; n++) begin
         tick();
         chk("scan_sel_a", cs_a, (n / 4) % 4); chk("scan_wrap_a", wr_a, int'(n % 16 == 0));
         chk("scan_sel_b", cs_b, (n / 4) % 3); chk("scan_wrap_b", wr_b, int'(n % 12 == 0));
         chk("scan_sel_c", cs_c, n % 4);       chk("scan_wrap_c", wr_c, int'(n % 4 == 0));
         wraps += int'(wr_a);
      end
      chk("scan_wrap_count_a", wraps, 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick(); tick();
      hold = 1'b1;
      for (int n = 0; n < 5; n++) begin
         tick(); chk("hold_sel_a", cs_a, 0); chk("hold_wrap_a", wr_a, 0);
      end
      hold = 1'b0;
      tick(); chk("hold_resume1", cs_a, 0);
      tick(); chk("hold_resume2", cs_a, 1);
      tick(); tick(); tick();
      hold = 1'b1;
      tick(); chk("hold_expiry", cs_a, 1);
      hold = 1'b0;
      tick(); chk("hold_expiry_release", cs_a, 2);
      mode = 1'b0; sel = 2'd2;
      tick(); chk("p1_manual", cs_c, 2);
      mode = 1'b1;
      tick(); chk("p1_auto1", cs_c, 3);
      tick(); chk("p1_auto2", cs_c, 0); chk("p1_wrap", wr_c, 1);
      mode = 1'b0; sel = 2'd1;
      tick(); chk("p1_back_manual", cs_c, 1);
      sel = 2'd3;
      tick(); tick(); tick();
      chk("reselect_out_a", out_a, 'h11);
      for (int n = 0; n < 600; n++) begin
         d = 28'($urandom);
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         hold  = $urandom_range(0, 3) == 0;
         sel   = 2'($urandom);
         reset = $urandom_range(0, 63) == 0;
         tick();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
